spi_se_exec: RTL and testbench

Executes one SPI-flash sector erase per request: on a `se_start` pulse it sends WRITE ENABLE (0x06), then SECTOR ERASE (0xD8) with a 24-bit address, and returns a one-cycle `se_end`. It sits between the erase sequencer and the flash pins of the configuration SPI flash in the multiboot design. The sequencer times its next request from `se_end`. This block walks the target sector address itself, wrapping after the last sector.

---
 rtl/spi_se_exec_if.sv | 24 ++
 rtl/spi_se_exec.sv | 155 +++++++++++++++
 tb/tb_spi_se_exec.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_se_exec_if.sv
// Sequencer/flash-side signal bundle for the sector-erase executor.
interface spi_se_exec_if;
    localparam int unsigned IDX_W = 4;

    logic             se_start;
    logic             cs_n;
    logic             sck;
    logic             mosi;
    logic             busy;
    logic             se_end;
    logic [IDX_W-1:0] sec_idx;

    // Sequencer / bench side: issues requests, observes pins and status.
    modport master (
        output se_start,
        input  cs_n, sck, mosi, busy, se_end, sec_idx
    );

    // Executor side.
    modport slave (
        input  se_start,
        output cs_n, sck, mosi, busy, se_end, sec_idx
    );
endinterface

// File: rtl/spi_se_exec.sv
// SPI-flash sector erase executor: WREN, cs_n gap, SE + 24-bit address,
// then a one-cycle se_end. Walks the sector index itself, wrapping after SECTOR.
module spi_se_exec #(
    parameter logic [23:0] BASE_ADDR = 24'h000000,
    parameter logic [23:0] SECT_STEP = 24'h010000,
    parameter int unsigned SECTOR    = 7,
    parameter int unsigned GAP       = 8     // 1..256
) (
    input  logic         sclk,
    input  logic         rst_n,
    spi_se_exec_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 4;
    localparam logic [CNT_W-1:0] WREN_LAST = CNT_W'(8 * 4 - 1);
    localparam logic [CNT_W-1:0] SE_LAST   = CNT_W'(32 * 4 - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [7:0]       CMD_WREN  = 8'h06;
    localparam logic [7:0]       CMD_SE    = 8'hD8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREN,
        S_GAP,
        S_SE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;          // cycle within current state; [1:0] is the bit phase
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [23:0]      r_addr;
    logic [IDX_W-1:0] r_sec_idx;
    logic             w_accept;

    logic             r_cs_n;
    logic             r_sck;
    logic             r_mosi;
    logic             r_busy;
    logic             r_se_end;
    logic             w_cs_n;
    logic             w_sck;
    logic             w_mosi;
    logic             w_busy;
    logic             w_se_end;
    logic             w_in_frame;
    logic [31:0]      w_frame;
    logic [4:0]       w_bit;

    assign w_accept = (r_state == S_IDLE) && bus.se_start;

    // State and in-state cycle counter.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: each frame/gap runs a fixed number of cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.se_start) begin
                    w_state_nxt = S_WREN;
                end
            end
            S_WREN: begin
                if (r_cnt == WREN_LAST) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_SE;
                    w_cnt_nxt   = '0;
                end
            end
            S_SE: begin
                if (r_cnt == SE_LAST) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Pin values for the coming cycle, derived from next state so they register in step.
    always_comb begin
        w_in_frame = (w_state_nxt == S_WREN) || (w_state_nxt == S_SE);
        w_frame    = (w_state_nxt == S_WREN) ? {CMD_WREN, 24'h000000} : {CMD_SE, r_addr};
        w_bit      = 5'd31 - w_cnt_nxt[6:2];
        w_cs_n     = !w_in_frame;
        w_sck      = w_in_frame && w_cnt_nxt[1];
        w_mosi     = w_in_frame && w_frame[w_bit];
        w_busy     = w_in_frame || (w_state_nxt == S_GAP);
        w_se_end   = (w_state_nxt == S_DONE);
    end

    // Registered pins and status.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n   <= 1'b1;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
            r_busy   <= 1'b0;
            r_se_end <= 1'b0;
        end else begin
            r_cs_n   <= w_cs_n;
            r_sck    <= w_sck;
            r_mosi   <= w_mosi;
            r_busy   <= w_busy;
            r_se_end <= w_se_end;
        end
    end

    // Address latched on acceptance; sector index advances (and wraps) on DONE.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_sec_idx <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= BASE_ADDR + 24'(r_sec_idx) * SECT_STEP;
            end
            if (r_state == S_DONE) begin
                r_sec_idx <= (r_sec_idx == IDX_W'(SECTOR)) ? '0 : r_sec_idx + IDX_W'(1);
            end
        end
    end

    assign bus.cs_n    = r_cs_n;
    assign bus.sck     = r_sck;
    assign bus.mosi    = r_mosi;
    assign bus.busy    = r_busy;
    assign bus.se_end  = r_se_end;
    assign bus.sec_idx = r_sec_idx;

endmodule

// File: tb/tb_spi_se_exec.sv
// Bench for spi_se_exec: two instances (defaults; BASE=FF0000 with GAP=2),
// stimulus pushes expected erases, a monitor decodes the SPI pins and compares.
module tb_spi_se_exec;
    localparam int unsigned NI     = 2;
    localparam int unsigned STEP   = 32'h0001_0000;
    localparam int unsigned SECTOR = 7;

    typedef struct {
        int          inst;
        logic [23:0] addr;
        int          idx_after;
        int          gap;
        int          lat;
    } exp_t;

    logic          sclk  = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] r_start = '0;
    logic [NI-1:0] w_cs_n, w_sck, w_mosi, w_busy, w_se_end;
    logic [3:0]    w_idx [NI];

    exp_t exp_q[$];
    int   mdl_idx [NI];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   r_final  = 1'b0;

    always #10 sclk = ~sclk;

    for (genvar g = 0; g < NI; g++) begin : u
        spi_se_exec_if bus ();
        assign bus.se_start = r_start[g];
        assign w_cs_n[g]    = bus.cs_n;
        assign w_sck[g]     = bus.sck;
        assign w_mosi[g]    = bus.mosi;
        assign w_busy[g]    = bus.busy;
        assign w_se_end[g]  = bus.se_end;
        assign w_idx[g]     = bus.sec_idx;
        spi_se_exec #(
            .BASE_ADDR (g == 0 ? 24'h000000 : 24'hFF0000),
            .SECT_STEP (24'h010000),
            .SECTOR    (7),
            .GAP       (g == 0 ? 8 : 2)
        ) dut (
            .sclk  (sclk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic int unsigned base_of(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'h00FF_0000;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int          m_t [NI], m_nb [NI], m_nfr [NI], m_gap [NI], m_n0 [NI], m_n1 [NI], m_exp_idx [NI];
    logic [31:0] m_sh [NI], m_f0 [NI], m_f1 [NI];
    bit          m_act [NI], m_pend [NI], m_prev_cs [NI], m_prev_sck [NI];
    bit          m_final_done = 1'b0;

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d t=%0t: got 0x%0h expected 0x%0h", name, i, $time, got, exp);
        end
    endtask

    always @(negedge sclk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                chk("reset_outputs", i,
                    32'({w_cs_n[i], w_sck[i], w_mosi[i], w_busy[i], w_se_end[i], w_idx[i]}),
                    32'h100);
                m_act[i]      = 1'b0;
                m_pend[i]     = 1'b0;
                m_prev_cs[i]  = 1'b1;
                m_prev_sck[i] = 1'b0;
            end else begin
                if (m_pend[i]) begin
                    chk("sec_idx_after_end", i, 32'(w_idx[i]), 32'(m_exp_idx[i]));
                    m_pend[i] = 1'b0;
                end
                if (m_act[i]) m_t[i]++;
                if (!w_cs_n[i] && m_prev_cs[i]) begin
                    if (!m_act[i]) begin
                        m_act[i] = 1'b1;
                        m_t[i]   = 1;
                        m_nfr[i] = 0;
                        m_gap[i] = 0;
                    end
                    m_nb[i] = 0;
                    m_sh[i] = '0;
                end
                if (!w_cs_n[i] && w_sck[i] && !m_prev_sck[i]) begin
                    m_sh[i] = {m_sh[i][30:0], w_mosi[i]};
                    m_nb[i]++;
                end
                if (w_cs_n[i] && !m_prev_cs[i]) begin
                    if (m_nfr[i] == 0) begin
                        m_f0[i] = m_sh[i];
                        m_n0[i] = m_nb[i];
                    end else begin
                        m_f1[i] = m_sh[i];
                        m_n1[i] = m_nb[i];
                    end
                    m_nfr[i]++;
                end
                if (m_act[i] && w_cs_n[i] && m_nfr[i] == 1) m_gap[i]++;
                if (w_cs_n[i]) chk("idle_lines_sck_mosi", i, 32'({w_sck[i], w_mosi[i]}), 32'h0);
                if (m_act[i]) chk("busy_level", i, 32'(w_busy[i]), 32'(!w_se_end[i]));
                if (w_se_end[i]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_se_end inst=%0d t=%0t: got se_end=1 expected none", i, $time);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("end_instance", i, 32'(i), 32'(e.inst));
                        chk("wren_bits", i, 32'(m_n0[i]), 32'd8);
                        chk("wren_frame", i, m_f0[i], 32'h06);
                        chk("se_bits", i, 32'(m_n1[i]), 32'd32);
                        chk("se_frame", i, m_f1[i], {8'hD8, e.addr});
                        chk("gap_cycles", i, 32'(m_gap[i]), 32'(e.gap));
                        chk("end_latency", i, 32'(m_t[i]), 32'(e.lat));
                        chk("done_cs_n", i, 32'(w_cs_n[i]), 32'd1);
                        m_pend[i]    = 1'b1;
                        m_exp_idx[i] = e.idx_after;
                    end
                    m_act[i] = 1'b0;
                end
                m_prev_cs[i]  = w_cs_n[i];
                m_prev_sck[i] = w_sck[i];
            end
        end
        if (r_final && !m_final_done) begin
            chk("pending_expected_ends", 0, 32'(exp_q.size()), 32'd0);
            m_final_done = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    // Issue one request (in the current cycle) plus up to three extra pulses at the
    // given cycle numbers (0 = unused, ascending); return aligned to cycle lat+1.
    task automatic do_req(input int i, input int p0, input int p1, input int p2);
        exp_t e;
        int   lat;
        int   cur;
        int   pc [3];
        lat    = 161 + gap_of(i);
        e.inst = i;
        e.addr = 24'((base_of(i) + 32'(mdl_idx[i]) * STEP) % 32'h0100_0000);
        e.gap  = gap_of(i);
        e.lat  = lat;
        mdl_idx[i]  = (mdl_idx[i] == int'(SECTOR)) ? 0 : mdl_idx[i] + 1;
        e.idx_after = mdl_idx[i];
        exp_q.push_back(e);
        r_start[i] = 1'b1;
        @(posedge sclk);
        #1 r_start[i] = 1'b0;
        cur = 1;
        pc  = '{p0, p1, p2};
        for (int k = 0; k < 3; k++) begin
            if (pc[k] >= cur) begin
                repeat (pc[k] - cur) @(posedge sclk);
                #1 r_start[i] = 1'b1;
                @(posedge sclk);
                #1 r_start[i] = 1'b0;
                cur = pc[k] + 1;
            end
        end
        repeat (lat + 1 - cur) @(posedge sclk);
        #1;
    endtask

    initial begin
        int i;
        int lat;
        int pulse;
        mdl_idx = '{0, 0};
        repeat (3) @(posedge sclk);
        #1 rst_n = 1'b1;
        @(posedge sclk);
        #1;

        // Nine back-to-back requests: sectors 0..7 then wrap to 0.
        for (int k = 0; k < 9; k++) do_req(0, 0, 0, 0);

        // Pulses during WREN, SE and DONE are ignored.
        do_req(0, 5, 100, 169);

        // Base near the top of the address space wraps modulo 2^24; short gap.
        do_req(1, 0, 0, 0);
        do_req(1, 0, 0, 0);

        // Random mix of instances, idle spacing and ignored mid-sequence pulses.
        for (int k = 0; k < 12; k++) begin
            i   = int'($urandom_range(0, 1));
            lat = 161 + gap_of(i);
            repeat ($urandom_range(0, 3)) @(posedge sclk);
            #1;
            pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, lat)) : 0;
            do_req(i, pulse, 0, 0);
        end

        // Reset in the middle of the SE frame aborts with no se_end.
        r_start[0] = 1'b1;
        @(posedge sclk);
        #1 r_start[0] = 1'b0;
        repeat (59) @(posedge sclk);
        #3 rst_n = 1'b0;
        mdl_idx = '{0, 0};
        repeat (2) @(posedge sclk);
        #1 rst_n = 1'b1;
        repeat (200) @(posedge sclk);
        #1;

        // After reset both instances restart from sector 0.
        do_req(0, 0, 0, 0);
        do_req(1, 0, 0, 0);

        repeat (20) @(posedge sclk);
        r_final = 1'b1;
        repeat (3) @(negedge sclk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
